// File: rtl/tf_pkg.sv
// Shared definitions for the twiddle-factor address generator.
//   STAGE_W    : width of the stage index carried on tf_stage
//   tf_state_e : control states (idle, table load, read sweep, drain)
//   tf_off()   : first table row of stage s
//   tf_total() : total table rows T for a given LOGN
package tf_pkg;

    localparam int unsigned STAGE_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } tf_state_e;

    // Stage k owns 2^k rows until the rows reach N/4 (one row per cycle).
    function automatic int unsigned tf_off(input int unsigned s, input int unsigned logn);
        int unsigned off;
        off = 0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (k < s) begin
                if (k + 2 < logn) off += (32'd1 << k);
                else              off += (32'd1 << (logn - 2));
            end
        end
        return off;
    endfunction

    function automatic int unsigned tf_total(input int unsigned logn);
        return tf_off(logn, logn);
    endfunction

endpackage

// File: rtl/tf_sched_cnt.sv
// Stage/cycle schedule counter for the twiddle read sweep.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   init_i       : load the first (stage, cycle) of a sweep
//   inv_i        : with init_i, select the inverse sweep (stages descending)
//   adv_i        : advance one cycle; low holds the counters (stall)
//   stage_o      : current stage s
//   addr_o       : ROM address for (s, c)
//   last_o       : current (s, c) is the final read of the sweep
module tf_sched_cnt import tf_pkg::*; #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LOGN   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               init_i,
    input  logic               inv_i,
    input  logic               adv_i,
    output logic [STAGE_W-1:0] stage_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               last_o
);

    localparam int unsigned CW  = LOGN - 2;
    localparam int unsigned TOT = tf_total(LOGN);

    logic [CW-1:0]      c_q;
    logic [STAGE_W-1:0] s_q;
    logic               inv_q;
    logic               c_wrap;
    int unsigned        sh;
    int unsigned        base;

    assign c_wrap = (c_q == {CW{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_q   <= '0;
            s_q   <= '0;
            inv_q <= 1'b0;
        end else if (init_i) begin
            c_q   <= '0;
            s_q   <= inv_i ? STAGE_W'(LOGN - 1) : '0;
            inv_q <= inv_i;
        end else if (adv_i) begin
            c_q <= c_q + 1'b1;
            if (c_wrap) s_q <= inv_q ? s_q - 1'b1 : s_q + 1'b1;
        end
    end

    assign stage_o = s_q;
    assign last_o  = c_wrap && (inv_q ? (s_q == '0) : (s_q == STAGE_W'(LOGN - 1)));

    // Early stages reuse one twiddle row for several cycles: shift c down.
    always_comb begin
        sh     = (32'(s_q) + 2 < LOGN) ? LOGN - 2 - 32'(s_q) : 32'd0;
        base   = inv_q ? TOT : 32'd0;
        addr_o = ADDR_W'(base + tf_off(32'(s_q), LOGN) + (32'(c_q) >> sh));
    end

endmodule

// File: rtl/tf_addr_gen.sv
// Twiddle-factor ROM controller for the radix-2, 2-BFU NTT datapath.
// Loads the ROM through its write port, then walks the stage/cycle schedule issuing
// one read per unstalled cycle; tf_* tags are registered so they align with ROM Q.
// Optional: define TF_INTT_EN to add start_inv_i (inverse sweep, table at offset T).
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : pulse, begin forward sweep
//   start_inv_i           : pulse, begin inverse sweep (TF_INTT_EN only)
//   stall_i               : BFU back-pressure, freezes the sweep
//   ld_valid_i/data/last  : table load stream
//   busy_o, done_o        : activity flag, end-of-sweep pulse
//   rom_A/D/EN/REN_o      : ROM port (REN=1 read, 0 write)
//   tf_valid/stage/last_o : qualifiers for the word on ROM Q
module tf_addr_gen import tf_pkg::*; #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 28,
    parameter int unsigned LOGN   = 8,
    parameter int unsigned DEPTH  = 767
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
`ifdef TF_INTT_EN
    input  logic               start_inv_i,
`endif
    input  logic               stall_i,
    input  logic               ld_valid_i,
    input  logic [DATA_W-1:0]  ld_data_i,
    input  logic               ld_last_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ADDR_W-1:0]  rom_A_o,
    output logic [DATA_W-1:0]  rom_D_o,
    output logic               rom_EN_o,
    output logic               rom_REN_o,
    output logic               tf_valid_o,
    output logic [STAGE_W-1:0] tf_stage_o,
    output logic               tf_last_o
);

    tf_state_e          state_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic               tf_valid_q;
    logic [STAGE_W-1:0] tf_stage_q;
    logic               tf_last_q;
    logic               done_q;

    logic               inv_req;
    logic               issue;
    logic               sched_init;
    logic               sched_last;
    logic [STAGE_W-1:0] sched_stage;
    logic [ADDR_W-1:0]  sched_addr;

`ifdef TF_INTT_EN
    assign inv_req = start_inv_i;
`else
    assign inv_req = 1'b0;
`endif

    assign issue      = !rst_i && (state_q == StRun) && !stall_i;
    // Load has priority over a sweep request in idle.
    assign sched_init = !rst_i && (state_q == StIdle) && !ld_valid_i && (start_i || inv_req);

    tf_sched_cnt #(
        .ADDR_W (ADDR_W),
        .LOGN   (LOGN)
    ) u_sched (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .init_i  (sched_init),
        .inv_i   (inv_req && !start_i),
        .adv_i   (issue),
        .stage_o (sched_stage),
        .addr_o  (sched_addr),
        .last_o  (sched_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            tf_valid_q <= 1'b0;
            tf_stage_q <= '0;
            tf_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tf_valid_q <= issue;
            done_q     <= issue && sched_last;
            // Tags hold while stalled so they keep matching the held ROM Q.
            if (issue) begin
                tf_stage_q <= sched_stage;
                tf_last_q  <= sched_last;
            end
            unique case (state_q)
                StIdle, StLoad: begin
                    if (ld_valid_i) begin
                        if (ld_last_i || (wr_ptr_q == ADDR_W'(DEPTH - 1))) begin
                            state_q  <= StIdle;
                            wr_ptr_q <= '0;
                        end else begin
                            state_q  <= StLoad;
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end else if ((state_q == StIdle) && (start_i || inv_req)) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (issue && sched_last) state_q <= StDrain;
                end
                StDrain: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rom_EN_o  = 1'b0;
        rom_REN_o = 1'b1;
        rom_A_o   = '0;
        rom_D_o   = '0;
        if (!rst_i) begin
            unique case (state_q)
                StIdle, StLoad: begin
                    if (ld_valid_i) begin
                        rom_EN_o  = 1'b1;
                        rom_REN_o = 1'b0;
                        rom_A_o   = wr_ptr_q;
                        rom_D_o   = ld_data_i;
                    end
                end
                StRun: begin
                    rom_A_o  = sched_addr;
                    rom_EN_o = !stall_i;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign tf_valid_o = tf_valid_q;
    assign tf_stage_o = tf_stage_q;
    assign tf_last_o  = tf_last_q;

endmodule

// File: tb/tb_tf_addr_gen.sv
module tb_tf_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
`ifdef TF_INTT_EN
    logic        start_inv;
`endif
    logic        stall;
    logic        ld_valid;
    logic [27:0] ld_data;
    logic        ld_last;
    logic        busy;
    logic        done;
    logic [9:0]  rom_A;
    logic [27:0] rom_D;
    logic        rom_EN;
    logic        rom_REN;
    logic        tf_valid;
    logic [3:0]  tf_stage;
    logic        tf_last;

    always #5 clk = ~clk;

    tf_addr_gen dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
`ifdef TF_INTT_EN
        .start_inv_i (start_inv),
`endif
        .stall_i     (stall),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .ld_last_i   (ld_last),
        .busy_o      (busy),
        .done_o      (done),
        .rom_A_o     (rom_A),
        .rom_D_o     (rom_D),
        .rom_EN_o    (rom_EN),
        .rom_REN_o   (rom_REN),
        .tf_valid_o  (tf_valid),
        .tf_stage_o  (tf_stage),
        .tf_last_o   (tf_last)
    );

    // Behavioural ROM with one-cycle registered read.
    logic [27:0] mem [0:766];
    logic [27:0] rom_q;
    always @(posedge clk) begin
        if (rom_EN && !rom_REN) mem[rom_A] <= rom_D;
        if (rom_EN && rom_REN)  rom_q <= mem[rom_A];
    end

    typedef struct { int addr; int stage; int last; } rd_exp_t;
    typedef struct { int addr; int data; } wr_exp_t;
    rd_exp_t rq[$];
    wr_exp_t wq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int rd_cnt   = 0;
    bit done_seen = 0;

    // Hand-computed OFF(s) and c-shift for LOGN=8.
    int off_tab[9] = '{0, 1, 3, 7, 15, 31, 63, 127, 191};
    int sh_tab[8]  = '{6, 5, 4, 3, 2, 1, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT writes or presents a twiddle word.
    always @(negedge clk) begin
        rd_exp_t e;
        wr_exp_t w;
        if (rom_EN && rom_REN) rd_cnt++;
        if (rom_EN && !rom_REN) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", int'(rom_A), w.addr);
                chk("wr_data", int'(rom_D), w.data);
            end
        end
        if (tf_valid) begin
            if (rq.size() == 0) chk("unexpected_tf_valid", 1, 0);
            else begin
                e = rq.pop_front();
                chk("tf_word", int'(rom_q), e.addr);
                chk("tf_stage", int'(tf_stage), e.stage);
                chk("tf_last", int'(tf_last), e.last);
                chk("done_align", int'(done), e.last);
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
            end
        end else if (done) begin
            chk("done_without_valid", 1, 0);
        end
    end

    task automatic push_sweep(input bit inv);
        rd_exp_t e;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = inv ? 7 - i : i;
            for (int c = 0; c < 64; c++) begin
                e.addr  = (inv ? 191 : 0) + off_tab[s] + (c >> sh_tab[s]);
                e.stage = s;
                e.last  = (i == 7 && c == 63) ? 1 : 0;
                rq.push_back(e);
            end
        end
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic do_load(input int n);
        wr_exp_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = i;
            w.data = i;
            wq.push_back(w);
            ld_valid = 1'b1;
            ld_data  = 28'(i);
            ld_last  = (i == n - 1);
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        #1;
        chk("load_busy_after", int'(busy), 0);
        chk("load_all_written", wq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Interval j counts cycles after start is sampled; read j issues in interval j
    // when nothing stalls.
    task automatic sweep(input bit inv, input int stall_k, input int stall_addr,
                         input bit noise, input int rst_k, input int exp_lat);
        int start_cyc;
        push_sweep(inv);
        done_seen = 0;
        rd_cnt    = 0;
`ifdef TF_INTT_EN
        if (inv) start_inv = 1'b1;
        else     start = 1'b1;
`else
        start = 1'b1;
`endif
        start_cyc = cyc;
        @(posedge clk);
        for (int j = 0; j < 700; j++) begin
            #1;
            if (j == 0) begin
                start = 1'b0;
`ifdef TF_INTT_EN
                start_inv = 1'b0;
`endif
            end
            stall = (stall_k >= 0 && j >= stall_k && j < stall_k + 5);
            rst   = (rst_k >= 0 && j == rst_k);
            if (noise) begin
                start    = (j == 40 || j == exp_lat - 1);
                ld_valid = (j == 40);
                ld_data  = 28'd99;
                ld_last  = (j == 40);
            end
            @(negedge clk);
            #1;
            if (j == 0) begin
                chk("first_addr", int'(rom_A), inv ? 318 : 0);
                chk("first_busy", int'(busy), 1);
            end
            if (stall_k >= 0 && j >= stall_k && j < stall_k + 5) begin
                chk("stall_addr", int'(rom_A), stall_addr);
                chk("stall_en", int'(rom_EN), 0);
                if (j > stall_k) chk("stall_tf_valid", int'(tf_valid), 0);
            end
            if (rst_k >= 0 && j == rst_k) chk("rst_cycle_en", int'(rom_EN), 0);
            if (rst_k >= 0 && j == rst_k + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_tf_valid", int'(tf_valid), 0);
                break;
            end
            if (done_seen) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        stall    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (rst_k >= 0) begin
            rq.delete();
            wq.delete();
        end else begin
            chk("done_seen", int'(done_seen), 1);
            chk("done_latency", done_cyc - start_cyc, exp_lat);
            chk("read_count", rd_cnt, 512);
            chk("all_words_seen", rq.size(), 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            #1;
            chk("idle_after_sweep", int'(busy), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
`ifdef TF_INTT_EN
        start_inv = 1'b0;
`endif
        stall    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_A", int'(rom_A), 0);
        chk("rst_rom_D", int'(rom_D), 0);
        chk("rst_rom_EN", int'(rom_EN), 0);
        chk("rst_rom_REN", int'(rom_REN), 1);
        chk("rst_tf_valid", int'(tf_valid), 0);
        chk("rst_tf_stage", int'(tf_stage), 0);
        chk("rst_tf_last", int'(tf_last), 0);
        @(posedge clk);
        #1;

        do_load(191);
        sweep(1'b0, -1, 0, 1'b0, -1, 513);    // plain forward sweep
        sweep(1'b0, 202, 8, 1'b0, -1, 518);   // stall at stage 3, c=10
        sweep(1'b0, -1, 0, 1'b1, -1, 513);    // start/ld_valid noise while busy
        sweep(1'b0, -1, 0, 1'b0, 330, 513);   // reset in stage 5
        sweep(1'b0, -1, 0, 1'b0, -1, 513);    // restart after reset
`ifdef TF_INTT_EN
        do_load(382);
        sweep(1'b1, -1, 0, 1'b0, -1, 513);    // inverse sweep
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
